gpio_serial_config: RTL and testbench
=====================================

GPIO_SERIAL_CONFIG -- requirements
Module: gpio_serial_config

Interface
REQ-001 Parameter: NBITS, default 13, sets the GPIO configuration word width; only 13 is supported.
REQ-002 Port: wb_clk_i  input  1  the block's only clock; all state changes on its rising edge.
REQ-003 Port: wb_rst_i  input  1  reset, synchronous and active-high.
REQ-004 Port: gpio_defaults  input  13  default configuration word from the pad defaults block.
REQ-005 Port: serial_data_in  input  1  serial configuration bit, MSB first.
REQ-006 Port: serial_shift  input  1  one-cycle strobe that shifts serial_data_in in.
REQ-007 Port: serial_load  input  1  one-cycle strobe that commits the shifted word.
REQ-008 Port: defaults_reload  input  1  one-cycle strobe that restores gpio_defaults.
REQ-009 Port: serial_data_out  output  1  shift_reg[12], daisy-chain output.
REQ-010 Port: gpio_config  output  13  active configuration word.
REQ-011 Port: load_done  output  1  one-cycle pulse when a commit is accepted.
REQ-012 Port: load_err  output  1  one-cycle pulse when a commit is rejected.
REQ-013 Port: mgmt_ena, out_dis, hold_ovr, inp_dis, ib_mode, ana_en, ana_sel, ana_pol, slow_sel, vtrip_sel  output  1 each  decode of gpio_config bits 0..9, in that order.
REQ-014 Port: dm  output  3  gpio_config[12:10].

Function
REQ-015 The shift register shall be 13 bits; on serial_shift it takes {shift_reg[11:0], serial_data_in}.
REQ-016 The bit counter shall be 4 bits: +1 per shift, saturating at 13.
REQ-017 State shall derive from the counter: IDLE (0), SHIFTING (1..12), ARMED (13); extra shifts in ARMED stay ARMED, so the word passes down the chain.
REQ-018 serial_load in ARMED shall set gpio_config <= shift_reg, pulse load_done the next cycle, and clear the counter.
REQ-019 serial_load in IDLE or SHIFTING shall leave gpio_config unchanged, pulse load_err, and clear the counter.
REQ-020 serial_shift and serial_load in the same cycle: the commit decision and committed data shall use pre-shift shift_reg and count; the shift still occurs and the counter becomes 1.
REQ-021 defaults_reload shall set gpio_config <= gpio_defaults and clear the counter; shift_reg is unaffected.
REQ-022 When defaults_reload and serial_load coincide, reload shall win, and load_done and load_err shall both stay 0.
REQ-023 gpio_config changes one cycle after the commit or reload strobe; decoded outputs are combinational from gpio_config (no extra latency).
REQ-024 load_done and load_err shall never be high in the same cycle.

Reset
REQ-025 While wb_rst_i is high, every cycle shall set gpio_config <= gpio_defaults, shift_reg <= 0, counter <= 0, load_done <= 0, load_err <= 0.
REQ-026 Reset shall override all strobes; a word partly shifted when reset asserts is discarded.
REQ-027 The first strobes after wb_rst_i falls shall be honoured on that edge.

Structure
REQ-028 A shared package (gpio_cfg_pkg) shall hold the bit-index constants for fields 0..12, the DM encodings, NBITS, and the default word 13'h0402.
REQ-029 One sub-module, gpio_cfg_decode, shall be combinational and map gpio_config to the field outputs.

Verification
REQ-030 Reset with gpio_defaults=13'h0402 -> gpio_config=13'h0402, out_dis=1, dm=3'b001, serial_data_out=0.
REQ-031 Shift 13 bits of 13'h1803 MSB first, then pulse serial_load -> gpio_config=13'h1803 and load_done high for one cycle after the load edge; mgmt_ena=1, dm=3'b110.
REQ-032 Shift 7 bits then serial_load -> load_err pulses, gpio_config unchanged, counter returns to 0.
REQ-033 Shift 26 bits (word A, then word B) -> serial_data_out replays A's bits in order; serial_load commits B.
REQ-034 ARMED with 13'h1FFF and defaults_reload coincident with serial_load -> gpio_config=gpio_defaults, no load_done and no load_err.
REQ-035 Assert wb_rst_i after 5 shifts, release it, then shift 13'h0001 and load -> commit succeeds with gpio_config=13'h0001.

Source files
------------

// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg
//   Shared definitions for the GPIO serial configuration slice:
//   configuration word width, field bit positions, drive-mode encodings,
//   the pad default word, and the shift-state type derived from the bit
//   counter.
package gpio_cfg_pkg;

  localparam int NBITS = 13;

  // Field bit positions inside the configuration word
  localparam int IDX_MGMT_ENA  = 0;
  localparam int IDX_OUT_DIS   = 1;
  localparam int IDX_HOLD_OVR  = 2;
  localparam int IDX_INP_DIS   = 3;
  localparam int IDX_IB_MODE   = 4;
  localparam int IDX_ANA_EN    = 5;
  localparam int IDX_ANA_SEL   = 6;
  localparam int IDX_ANA_POL   = 7;
  localparam int IDX_SLOW_SEL  = 8;
  localparam int IDX_VTRIP_SEL = 9;
  localparam int IDX_DM_LSB    = 10;
  localparam int IDX_DM_MSB    = 12;

  // Pad drive-mode encodings carried in the dm field
  localparam logic [2:0] DM_ANALOG        = 3'b000;
  localparam logic [2:0] DM_INPUT_NOPULL  = 3'b001;
  localparam logic [2:0] DM_INPUT_PULLUP  = 3'b010;
  localparam logic [2:0] DM_OUTPUT_OD_LO  = 3'b011;
  localparam logic [2:0] DM_OUTPUT_OD_HI  = 3'b100;
  localparam logic [2:0] DM_OUTPUT_RES    = 3'b101;
  localparam logic [2:0] DM_OUTPUT_STRONG = 3'b110;
  localparam logic [2:0] DM_INPUT_PULLDN  = 3'b111;

  // Power-on default: input, no pull, output disabled
  localparam logic [NBITS-1:0] GPIO_DEFAULT_WORD = 13'h0402;

  // Bit counter value at which a complete word sits in the shift register
  localparam logic [3:0] CNT_FULL = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFTING = 2'd1,
    ST_ARMED    = 2'd2
  } cfg_state_e;

  // The shift state is not stored; it is a view of the bit counter.
  function automatic cfg_state_e state_of(input logic [3:0] cnt);
    if (cnt == 4'd0)          return ST_IDLE;
    else if (cnt >= CNT_FULL) return ST_ARMED;
    else                      return ST_SHIFTING;
  endfunction

endpackage

// File: rtl/gpio_cfg_decode.sv
// gpio_cfg_decode
//   Purely combinational split of the active configuration word into the
//   individual pad-control fields.
//   Ports:
//     gpio_config  in  13  active configuration word
//     mgmt_ena .. vtrip_sel  out  1 each  bits 0..9
//     dm           out  3   bits 12:10
module gpio_cfg_decode
  import gpio_cfg_pkg::*;
(
  input  logic [NBITS-1:0] gpio_config,
  output logic             mgmt_ena,
  output logic             out_dis,
  output logic             hold_ovr,
  output logic             inp_dis,
  output logic             ib_mode,
  output logic             ana_en,
  output logic             ana_sel,
  output logic             ana_pol,
  output logic             slow_sel,
  output logic             vtrip_sel,
  output logic [2:0]       dm
);

  assign mgmt_ena  = gpio_config[IDX_MGMT_ENA];
  assign out_dis   = gpio_config[IDX_OUT_DIS];
  assign hold_ovr  = gpio_config[IDX_HOLD_OVR];
  assign inp_dis   = gpio_config[IDX_INP_DIS];
  assign ib_mode   = gpio_config[IDX_IB_MODE];
  assign ana_en    = gpio_config[IDX_ANA_EN];
  assign ana_sel   = gpio_config[IDX_ANA_SEL];
  assign ana_pol   = gpio_config[IDX_ANA_POL];
  assign slow_sel  = gpio_config[IDX_SLOW_SEL];
  assign vtrip_sel = gpio_config[IDX_VTRIP_SEL];
  assign dm        = gpio_config[IDX_DM_MSB:IDX_DM_LSB];

endmodule

// File: rtl/gpio_serial_config.sv
// gpio_serial_config
//   Serial loader for one GPIO pad configuration word. Bits arrive MSB
//   first on serial_data_in; once 13 have been shifted the word is armed
//   and serial_load commits it. Further shifts while armed keep pushing
//   bits through serial_data_out so words can travel down a chain of pads.
//   Ports:
//     wb_clk_i         in   1   clock
//     wb_rst_i         in   1   synchronous active-high reset
//     gpio_defaults    in   13  pad default word (reset / reload value)
//     serial_data_in   in   1   serial bit
//     serial_shift     in   1   shift strobe
//     serial_load      in   1   commit strobe
//     defaults_reload  in   1   restore-defaults strobe
//     serial_data_out  out  1   MSB of the shift register (chain output)
//     gpio_config      out  13  active configuration word
//     load_done        out  1   commit accepted (one-cycle pulse)
//     load_err         out  1   commit rejected (one-cycle pulse)
//     mgmt_ena .. dm   out      field decode of gpio_config
module gpio_serial_config
  import gpio_cfg_pkg::*;
#(
  parameter int NBITS = gpio_cfg_pkg::NBITS
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [NBITS-1:0] gpio_defaults,
  input  logic             serial_data_in,
  input  logic             serial_shift,
  input  logic             serial_load,
  input  logic             defaults_reload,
  output logic             serial_data_out,
  output logic [NBITS-1:0] gpio_config,
  output logic             load_done,
  output logic             load_err,
  output logic             mgmt_ena,
  output logic             out_dis,
  output logic             hold_ovr,
  output logic             inp_dis,
  output logic             ib_mode,
  output logic             ana_en,
  output logic             ana_sel,
  output logic             ana_pol,
  output logic             slow_sel,
  output logic             vtrip_sel,
  output logic [2:0]       dm
);

  logic [NBITS-1:0] shift_reg;
  logic [3:0]       bit_cnt;
  cfg_state_e       state;
  logic [3:0]       cnt_base;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= CNT_FULL) ? CNT_FULL : c + 4'd1;
  endfunction

  assign state = state_of(bit_cnt);

  // A commit or reload restarts counting; a shift in the same cycle is
  // still counted on top of the restart, so the counter lands on 1.
  assign cnt_base = (serial_load || defaults_reload) ? 4'd0 : bit_cnt;

  assign serial_data_out = shift_reg[NBITS-1];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gpio_config <= gpio_defaults;
      shift_reg   <= '0;
      bit_cnt     <= 4'd0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;

      if (serial_shift) begin
        shift_reg <= {shift_reg[NBITS-2:0], serial_data_in};
        bit_cnt   <= sat_inc(cnt_base);
      end else begin
        bit_cnt   <= cnt_base;
      end

      // Commit decision uses the pre-shift state and shift_reg.
      if (defaults_reload) begin
        gpio_config <= gpio_defaults;
      end else if (serial_load) begin
        if (state == ST_ARMED) begin
          gpio_config <= shift_reg;
          load_done   <= 1'b1;
        end else begin
          load_err    <= 1'b1;
        end
      end
    end
  end

  gpio_cfg_decode u_decode (
    .gpio_config (gpio_config),
    .mgmt_ena    (mgmt_ena),
    .out_dis     (out_dis),
    .hold_ovr    (hold_ovr),
    .inp_dis     (inp_dis),
    .ib_mode     (ib_mode),
    .ana_en      (ana_en),
    .ana_sel     (ana_sel),
    .ana_pol     (ana_pol),
    .slow_sel    (slow_sel),
    .vtrip_sel   (vtrip_sel),
    .dm          (dm)
  );

endmodule

// File: tb/tb_gpio_serial_config.sv
// tb_gpio_serial_config
//   Directed bench for gpio_serial_config: a table of reload vectors for
//   the field decode, plus hand-written sequences for the serial commit,
//   rejection, chaining, coincident strobes and reset cases.
module tb_gpio_serial_config;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] gpio_defaults;
  logic        serial_data_in;
  logic        serial_shift;
  logic        serial_load;
  logic        defaults_reload;
  logic        serial_data_out;
  logic [12:0] gpio_config;
  logic        load_done;
  logic        load_err;
  logic        mgmt_ena, out_dis, hold_ovr, inp_dis, ib_mode;
  logic        ana_en, ana_sel, ana_pol, slow_sel, vtrip_sel;
  logic [2:0]  dm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gpio_serial_config #(.NBITS(13)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .gpio_defaults   (gpio_defaults),
    .serial_data_in  (serial_data_in),
    .serial_shift    (serial_shift),
    .serial_load     (serial_load),
    .defaults_reload (defaults_reload),
    .serial_data_out (serial_data_out),
    .gpio_config     (gpio_config),
    .load_done       (load_done),
    .load_err        (load_err),
    .mgmt_ena        (mgmt_ena),
    .out_dis         (out_dis),
    .hold_ovr        (hold_ovr),
    .inp_dis         (inp_dis),
    .ib_mode         (ib_mode),
    .ana_en          (ana_en),
    .ana_sel         (ana_sel),
    .ana_pol         (ana_pol),
    .slow_sel        (slow_sel),
    .vtrip_sel       (vtrip_sel),
    .dm              (dm)
  );

  typedef struct {
    logic [12:0] word;
    logic [2:0]  exp_dm;
    logic [9:0]  exp_flags;   // {vtrip_sel .. mgmt_ena}
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Strobes are held across exactly one rising edge; outputs are read 1ns later.
  task automatic tick(input logic sh, input logic d, input logic ld, input logic rl);
    serial_shift    = sh;
    serial_data_in  = d;
    serial_load     = ld;
    defaults_reload = rl;
    @(posedge clk);
    #1;
    serial_shift    = 1'b0;
    serial_load     = 1'b0;
    defaults_reload = 1'b0;
    serial_data_in  = 1'b0;
    chk("done_err_exclusive", {31'd0, load_done & load_err}, 32'd0);
  endtask

  task automatic shift_bits(input logic [12:0] w, input int n);
    for (int i = 12; i > 12 - n; i--) tick(1'b1, w[i], 1'b0, 1'b0);
  endtask

  logic [12:0] wa, wb, wc;
  logic [9:0]  flags;

  initial begin
    vt[0] = '{13'h0402, 3'b001, 10'b00_0000_0010};
    vt[1] = '{13'h1803, 3'b110, 10'b00_0000_0011};
    vt[2] = '{13'h0000, 3'b000, 10'b00_0000_0000};
    vt[3] = '{13'h1FFF, 3'b111, 10'b11_1111_1111};
    vt[4] = '{13'h0155, 3'b000, 10'b01_0101_0101};
    vt[5] = '{13'h0AAA, 3'b010, 10'b10_1010_1010};
    vt[6] = '{13'h1400, 3'b101, 10'b00_0000_0000};

    rst = 1'b1;
    gpio_defaults   = 13'h0402;
    serial_data_in  = 1'b0;
    serial_shift    = 1'b0;
    serial_load     = 1'b0;
    defaults_reload = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_cfg",     {19'd0, gpio_config}, 32'h0402);
    chk("rst_out_dis", {31'd0, out_dis},     32'd1);
    chk("rst_dm",      {29'd0, dm},          32'd1);
    chk("rst_sdo",     {31'd0, serial_data_out}, 32'd0);
    chk("rst_done",    {31'd0, load_done},   32'd0);
    chk("rst_err",     {31'd0, load_err},    32'd0);
    rst = 1'b0;

    // Full word commit
    shift_bits(13'h1803, 13);
    chk("arm_sdo", {31'd0, serial_data_out}, 32'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("commit_cfg",  {19'd0, gpio_config}, 32'h1803);
    chk("commit_done", {31'd0, load_done},   32'd1);
    chk("commit_err",  {31'd0, load_err},    32'd0);
    chk("commit_mgmt", {31'd0, mgmt_ena},    32'd1);
    chk("commit_dm",   {29'd0, dm},          32'h6);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_pulse_end", {31'd0, load_done}, 32'd0);

    // Short word rejected
    shift_bits(13'h1555, 7);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("short_err",  {31'd0, load_err},    32'd1);
    chk("short_done", {31'd0, load_done},   32'd0);
    chk("short_cfg",  {19'd0, gpio_config}, 32'h1803);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_pulse_end", {31'd0, load_err}, 32'd0);
    // Counter restarted from 0: 12 more bits are still not enough
    shift_bits(13'h0FFF, 12);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("cnt_cleared_err", {31'd0, load_err}, 32'd1);
    chk("cnt_cleared_cfg", {19'd0, gpio_config}, 32'h1803);

    // Field decode via reload table
    for (int i = 0; i < 7; i++) begin
      gpio_defaults = vt[i].word;
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      flags = {vtrip_sel, slow_sel, ana_pol, ana_sel, ana_en,
               ib_mode, inp_dis, hold_ovr, out_dis, mgmt_ena};
      chk($sformatf("tbl%0d_cfg", i),   {19'd0, gpio_config}, {19'd0, vt[i].word});
      chk($sformatf("tbl%0d_dm", i),    {29'd0, dm},          {29'd0, vt[i].exp_dm});
      chk($sformatf("tbl%0d_flags", i), {22'd0, flags},       {22'd0, vt[i].exp_flags});
      chk($sformatf("tbl%0d_nodone", i), {31'd0, load_done | load_err}, 32'd0);
    end
    gpio_defaults = 13'h0402;

    // Daisy chain: word A emerges on serial_data_out while B shifts in
    wa = 13'h0B3D;
    wb = 13'h1247;
    shift_bits(wa, 13);
    chk("chain_sdo0", {31'd0, serial_data_out}, {31'd0, wa[12]});
    for (int k = 1; k <= 12; k++) begin
      tick(1'b1, wb[13-k], 1'b0, 1'b0);
      chk($sformatf("chain_sdo%0d", k), {31'd0, serial_data_out}, {31'd0, wa[12-k]});
    end
    tick(1'b1, wb[0], 1'b0, 1'b0);
    chk("chain_sdo13", {31'd0, serial_data_out}, {31'd0, wb[12]});
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("chain_cfg",  {19'd0, gpio_config}, 32'h1247);
    chk("chain_done", {31'd0, load_done},   32'd1);

    // Shift and load together while armed: commit pre-shift word, count 1
    shift_bits(wa, 13);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    chk("coin_cfg",  {19'd0, gpio_config}, 32'h0B3D);
    chk("coin_done", {31'd0, load_done},   32'd1);
    wc = 13'h0ABC;
    for (int i = 11; i >= 0; i--) tick(1'b1, wc[i], 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("coin_next_done", {31'd0, load_done},   32'd1);
    chk("coin_next_cfg",  {19'd0, gpio_config}, 32'h1ABC);

    // Shift and load together while not armed: rejected
    shift_bits(13'h1FFF, 3);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    chk("coin_short_err", {31'd0, load_err},    32'd1);
    chk("coin_short_cfg", {19'd0, gpio_config}, 32'h1ABC);

    // Reload wins over a coincident load
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    shift_bits(13'h1FFF, 13);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk("rl_cfg",  {19'd0, gpio_config}, 32'h0402);
    chk("rl_done", {31'd0, load_done},   32'd0);
    chk("rl_err",  {31'd0, load_err},    32'd0);
    chk("rl_sdo_kept", {31'd0, serial_data_out}, 32'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rl_cnt_cleared", {31'd0, load_err}, 32'd1);

    // Reset mid-word, strobes ignored during reset
    shift_bits(13'h1FFF, 5);
    rst = 1'b1;
    gpio_defaults = 13'h0155;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk("mid_rst_cfg",  {19'd0, gpio_config}, 32'h0155);
    chk("mid_rst_sdo",  {31'd0, serial_data_out}, 32'd0);
    chk("mid_rst_done", {31'd0, load_done | load_err}, 32'd0);
    rst = 1'b0;
    // Partial word discarded: 8 bits after reset are not a full word
    shift_bits(13'h1FFF, 8);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_short_err", {31'd0, load_err}, 32'd1);
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    // First strobe honoured on the edge where reset is already low
    rst = 1'b0;
    shift_bits(13'h0001, 13);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_done", {31'd0, load_done},   32'd1);
    chk("post_rst_cfg",  {19'd0, gpio_config}, 32'h0001);
    chk("post_rst_mgmt", {31'd0, mgmt_ena},    32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
